stream_demux_router: RTL
========================

Name: stream_demux_router

Overview:
- Sequential inverse of a mux: routes one valid/ready input stream to one of N output channels, selected per transfer by up_sel.
- Each output channel has a one-entry holding register, so it presents registered data with 1-cycle latency.
- Transfers with an out-of-range select are discarded and counted.
- Sits between a single producer and N independent consumers in the homework sequential-logic section.

Parameters:
- W, 8, data width in bits.
- N, 3, number of output channels (≥2; need not be a power of two).
- SEL_W, $clog2(N), select width (derived; not overridden).
- CNT_W, 8, drop-counter width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- up_valid  input  1  input transfer offered.
- up_ready  output  1  input transfer can be accepted this cycle (combinational).
- up_sel  input  SEL_W  destination channel; qualified by up_valid.
- up_data  input  W  payload.
- dn_valid  output  N  per-channel holding register full (registered).
- dn_ready  input  N  per-channel consumer accepts.
- dn_data  output  N*W  channel k data at bits [k*W +: W] (registered).
- drop_cnt  output  CNT_W  count of discarded transfers (registered).

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset:
  - rst_n low clears dn_valid to 0 and drop_cnt to 0 immediately, independent of clk.
  - dn_data resets to 0.
  - Asserting reset mid-transfer discards any held data with no partial delivery.
  - After deassertion, the first accept occurs no earlier than the next posedge.
- Handshakes:
  - up handshake: accept = up_valid & up_ready at posedge.
  - dn handshake for channel k: pop_k = dn_valid[k] & dn_ready[k] at posedge.
- up_ready, in range (up_sel < N): up_ready = ~dn_valid[up_sel] | dn_ready[up_sel]. This passes through the consumer's ready, so an empty or draining channel accepts.
- up_ready, out of range (up_sel ≥ N): up_ready = 1.
- up_ready when up_valid = 0: up_ready still reflects up_sel per the rules above. Producers must not rely on this.
- up_ready is the only combinational path (dn_ready → up_ready). No path from up_valid to any output.
- Per channel k, each posedge:
  - accept to k (in range, up_sel = k): dn_data[k] ← up_data; dn_valid[k] ← 1. This also covers a simultaneous pop_k; data replaces in the same cycle with no bubble.
  - else if pop_k: dn_valid[k] ← 0; dn_data[k] holds its old value.
  - else: hold.
- Latency: data accepted at edge t is visible on dn_data/dn_valid after edge t. Throughput is 1 transfer/cycle per channel while the consumer holds dn_ready = 1.
- Channel independence: a stalled channel (dn_valid = 1, dn_ready = 0) only blocks transfers addressed to it. Other channels drain independently in the same cycle.
- Stability rule (producer side): while up_valid = 1 & up_ready = 0, the producer holds up_sel and up_data stable.
- Stability rule (block side): while dn_valid[k] = 1 & dn_ready[k] = 0, the block holds dn_data[k] stable.
- Out-of-range select:
  - An accept with up_sel ≥ N writes no channel.
  - drop_cnt increments by 1 and saturates at 2^CNT_W−1 (no wrap).
  - Only possible when N is not a power of two.
- No ordering guarantee across channels; in-order delivery within each channel.

Test Plan:
- Reset: drive rst_n=0 between clock edges with dn_valid[1]=1 held → dn_valid=3'b000 and drop_cnt=0 before the next posedge. Release rst_n; up_valid=1, sel=0, data=8'hA5 → dn_valid[0]=1, dn_data[7:0]=8'hA5 one cycle later.
- Routing sweep: all dn_ready=1; send sel=0/1/2 with data 8'h11/8'h22/8'h33 on consecutive cycles → each appears on its own channel 1 cycle after accept, with dn_valid a single-cycle pulse per channel.
- Backpressure: dn_ready[1]=0; send 8'h40 then 8'h41 to sel=1 → first accepted; up_ready=0 for the second and dn_data[1] stays 8'h40. Raise dn_ready[1] → 8'h41 is accepted in that same cycle (no bubble) and 8'h40 pops.
- Channel independence: channel 2 stalled full; send 8'h55 to sel=0 → accepted immediately and delivered on channel 0 next cycle; channel 2 unchanged.
- Drops: N=3; send sel=3 five times → up_ready=1 each time, no dn_valid change, drop_cnt=5. With CNT_W=2, send 6 drops → drop_cnt=3, saturated.
- Full stream: random sel/data/dn_ready for 1000 cycles → scoreboard per-channel FIFO order matches, no loss, no duplicate, and drop_cnt equals the number of out-of-range accepts (saturated).

Source files
------------

// File: rtl/stream_demux_router.sv
// One-to-N valid/ready demultiplexer with a one-entry holding register per channel.
// Out-of-range selects are consumed and counted in a saturating drop counter.
module stream_demux_router #(
  parameter int W     = 8,
  parameter int N     = 3,
  parameter int SEL_W = $clog2(N),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [SEL_W-1:0] up_sel,
  input  logic [W-1:0]     up_data,
  output logic [N-1:0]     dn_valid,
  input  logic [N-1:0]     dn_ready,
  output logic [N*W-1:0]   dn_data,
  output logic [CNT_W-1:0] drop_cnt
);

  logic         in_range;
  logic         accept;
  logic         drop;
  logic [N-1:0] load;
  logic [N-1:0] pop;

  assign in_range = 32'(up_sel) < N;
  assign accept   = up_valid & up_ready;
  assign drop     = accept & ~in_range;

  // A channel can take data when empty or when its consumer drains it this cycle.
  always_comb begin
    up_ready = 1'b1;
    if (in_range)
      up_ready = ~dn_valid[up_sel] | dn_ready[up_sel];
  end

  // Decode the accepted transfer into per-channel load strobes and pops.
  always_comb begin
    load = '0;
    pop  = dn_valid & dn_ready;
    for (int k = 0; k < N; k++)
      load[k] = accept & in_range & (up_sel == SEL_W'(k));
  end

  // Holding registers: a load wins over a pop so back-to-back data has no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= '0;
      dn_data  <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (load[k]) begin
          dn_valid[k]         <= 1'b1;
          dn_data[k*W +: W]   <= up_data;
        end else if (pop[k]) begin
          dn_valid[k]         <= 1'b0;
        end
      end
    end
  end

  // Saturating count of transfers accepted with no destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (drop && drop_cnt != '1)
      drop_cnt <= drop_cnt + CNT_W'(1);
  end

endmodule
